// File: rtl/uart_tx_feeder.sv
// Byte FIFO feeding a UART transmitter through a request/busy handshake.
// A request that the transmitter never acknowledges with busy is re-issued after RETRY_CYC cycles.
module uart_tx_feeder #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned RETRY_CYC = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               wr_data,
    input  logic                     wr_en,
    input  logic                     clr_ovf,
    input  logic                     tx_busy,
    output logic                     tx_req,
    output logic [7:0]               tx_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = (RETRY_CYC > 1) ? $clog2(RETRY_CYC) : 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAITB, S_WAITD} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] retry_q, retry_d;
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   level_q, level_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    tx_data_q;
    logic          tx_req_q;
    logic          pop, push, drop;

    assign full     = (level_q == (AW+1)'(DEPTH));
    assign empty    = (level_q == '0);
    assign level    = level_q;
    assign overflow = overflow_q;
    assign tx_req   = tx_req_q;
    assign tx_data  = tx_data_q;

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        pop     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!empty && !tx_busy) begin
                    pop     = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                state_d = S_WAITB;
                retry_d = '0;
            end
            S_WAITB: begin
                if (tx_busy) begin
                    state_d = S_WAITD;
                end else if (retry_q == CW'(RETRY_CYC - 1)) begin
                    // Transmitter never took the byte: pulse again with the same data.
                    state_d = S_REQ;
                end else begin
                    retry_d = retry_q + 1'b1;
                end
            end
            S_WAITD: begin
                if (!tx_busy) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A write while full is only accepted if the head leaves in the same cycle.
    always_comb begin
        push       = wr_en && (!full || pop);
        drop       = wr_en && full && !pop;
        level_d    = level_q;
        overflow_d = overflow_q;
        if (push && !pop) begin
            level_d = level_q + 1'b1;
        end else if (pop && !push) begin
            level_d = level_q - 1'b1;
        end
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            retry_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            tx_data_q  <= 8'h00;
            tx_req_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            retry_q    <= retry_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            tx_req_q   <= (state_d == S_REQ);
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_q  <= rd_ptr_q + 1'b1;
                tx_data_q <= mem_q[rd_ptr_q];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Randomized and directed bench for uart_tx_feeder against a queue-based transaction model.
module tb_uart_tx_feeder;

    localparam int DEPTH = 8;
    localparam int RETRY = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_en = 1'b0, clr_ovf = 1'b0, tx_busy = 1'b0;
    logic       tx_req, full, empty, overflow;
    logic [7:0] tx_data;
    logic [3:0] level;

    uart_tx_feeder #(.DEPTH(DEPTH), .RETRY_CYC(RETRY)) dut (
        .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .wr_en(wr_en), .clr_ovf(clr_ovf),
        .tx_busy(tx_busy), .tx_req(tx_req), .tx_data(tx_data), .full(full), .empty(empty),
        .level(level), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;

    // Model: queued bytes, the byte handed to the transmitter, and handshake progress.
    byte unsigned mq[$];
    logic [7:0]   m_txd = 8'h00;
    logic         m_ovf = 1'b0, m_req = 1'b0, m_hold = 1'b0, m_acked = 1'b0;
    int           m_quiet = 0;

    bit auto_resp = 1'b0;
    int resp_cnt = 0;
    int pulses = 0;

    task automatic model_step();
        bit was_full, mpop, mdrop, nreq;
        if (!rst_n) begin
            mq.delete();
            m_ovf = 0; m_req = 0; m_hold = 0; m_acked = 0; m_txd = 8'h00; m_quiet = 0;
        end else begin
            was_full = (mq.size() == DEPTH);
            mpop     = !m_hold && (mq.size() != 0) && !tx_busy;
            mdrop    = wr_en && was_full && !mpop;
            nreq     = 0;
            if (mpop) begin
                m_txd = mq.pop_front(); m_hold = 1; m_acked = 0; nreq = 1;
            end else if (m_hold && !m_acked) begin
                if (m_req) m_quiet = 0;
                else if (tx_busy) m_acked = 1;
                else begin
                    m_quiet++;
                    if (m_quiet == RETRY) begin nreq = 1; m_quiet = 0; end
                end
            end else if (m_hold && m_acked && !tx_busy) begin
                m_hold = 0;
            end
            m_req = nreq;
            if (wr_en && !mdrop) mq.push_back(wr_data);
            if (mdrop) m_ovf = 1;
            else if (clr_ovf) m_ovf = 0;
        end
    endtask

    // One clock: advance the model on the current inputs, then sample the DUT after the edge.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        if (tx_req === 1'b1) pulses++;
        if (auto_resp) begin
            if (tx_req === 1'b1) resp_cnt = 3;
            tx_busy = (resp_cnt > 0);
            if (resp_cnt > 0) resp_cnt--;
        end
    endtask

    task automatic test_reset();
        rst_n = 0; tick(); tick();
        n_vec++; if (level !== 4'd0) begin n_err++; $display("FAIL reset_level got %0d want 0", level); end
        n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got %b want 1", empty); end
        n_vec++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full got %b want 0", full); end
        n_vec++; if (tx_req !== 1'b0) begin n_err++; $display("FAIL reset_req got %b want 0", tx_req); end
        n_vec++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL reset_data got %h want 00", tx_data); end
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b want 0", overflow); end
        rst_n = 1;
    endtask

    task automatic test_single_byte();
        pulses = 0;
        wr_data = 8'hA5; wr_en = 1; tick(); wr_en = 0;
        n_vec++; if (tx_req !== 1'b0 || level !== 4'd1) begin
            n_err++; $display("FAIL single_push req=%b level=%0d want 0/1", tx_req, level); end
        tick();
        n_vec++; if (tx_req !== 1'b1 || tx_data !== 8'hA5 || level !== 4'd0) begin
            n_err++; $display("FAIL single_req req=%b data=%h level=%0d want 1/a5/0", tx_req, tx_data, level); end
        tick();
        n_vec++; if (tx_req !== 1'b0) begin n_err++; $display("FAIL single_req_len got %b want 0", tx_req); end
        tx_busy = 1; repeat (3) tick(); tx_busy = 0; repeat (4) tick();
        n_vec++; if (pulses != 1 || level !== 4'd0 || empty !== 1'b1 || tx_data !== 8'hA5) begin
            n_err++; $display("FAIL single_done pulses=%0d level=%0d empty=%b data=%h want 1/0/1/a5",
                              pulses, level, empty, tx_data); end
    endtask

    task automatic test_fill_order();
        byte unsigned got[$];
        tx_busy = 1;
        for (int i = 1; i <= 8; i++) begin wr_data = 8'(i); wr_en = 1; tick(); end
        wr_en = 0;
        n_vec++; if (full !== 1'b1 || level !== 4'd8 || overflow !== 1'b0) begin
            n_err++; $display("FAIL fill_full full=%b level=%0d ovf=%b want 1/8/0", full, level, overflow); end
        wr_data = 8'h09; wr_en = 1; tick(); wr_en = 0;
        n_vec++; if (overflow !== 1'b1 || level !== 4'd8) begin
            n_err++; $display("FAIL fill_drop ovf=%b level=%0d want 1/8", overflow, level); end
        auto_resp = 1; resp_cnt = 0; tx_busy = 0;
        for (int c = 0; c < 300 && got.size() < 8; c++) begin
            tick();
            if (tx_req === 1'b1) got.push_back(tx_data);
        end
        n_vec++; if (got.size() != 8) begin n_err++; $display("FAIL fill_count got %0d want 8", got.size()); end
        for (int i = 0; i < got.size(); i++) begin
            n_vec++; if (got[i] != byte'(i + 1)) begin
                n_err++; $display("FAIL fill_order[%0d] got %h want %h", i, got[i], i + 1); end
        end
        repeat (8) tick();
        n_vec++; if (level !== 4'd0 || empty !== 1'b1) begin
            n_err++; $display("FAIL fill_drain level=%0d empty=%b want 0/1", level, empty); end
    endtask

    task automatic test_push_pop_full();
        byte unsigned got[$];
        auto_resp = 0; tx_busy = 1; clr_ovf = 1; tick(); clr_ovf = 0;
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ppf_clr got %b want 0", overflow); end
        for (int i = 0; i < 8; i++) begin wr_data = 8'h10 + 8'(i); wr_en = 1; tick(); end
        n_vec++; if (level !== 4'd8 || full !== 1'b1) begin
            n_err++; $display("FAIL ppf_fill level=%0d full=%b want 8/1", level, full); end
        auto_resp = 1; resp_cnt = 0;
        tx_busy = 0; wr_data = 8'h5A; wr_en = 1; tick(); wr_en = 0;
        n_vec++; if (level !== 4'd8 || overflow !== 1'b0 || tx_req !== 1'b1 || tx_data !== 8'h10) begin
            n_err++; $display("FAIL ppf_same level=%0d ovf=%b req=%b data=%h want 8/0/1/10",
                              level, overflow, tx_req, tx_data); end
        for (int c = 0; c < 300 && got.size() < 8; c++) begin
            tick();
            if (tx_req === 1'b1) got.push_back(tx_data);
        end
        n_vec++; if (got.size() != 8) begin n_err++; $display("FAIL ppf_count got %0d want 8", got.size()); end
        for (int i = 0; i < got.size(); i++) begin
            n_vec++; if (got[i] != ((i == 7) ? 8'h5A : 8'h11 + 8'(i))) begin
                n_err++; $display("FAIL ppf_order[%0d] got %h", i, got[i]); end
        end
        repeat (8) tick();
    endtask

    task automatic test_retry();
        auto_resp = 0; tx_busy = 0;
        wr_data = 8'hC3; wr_en = 1; tick(); wr_data = 8'h3C; tick(); wr_en = 0;
        n_vec++; if (tx_req !== 1'b1 || tx_data !== 8'hC3 || level !== 4'd1) begin
            n_err++; $display("FAIL retry_first req=%b data=%h level=%0d want 1/c3/1", tx_req, tx_data, level); end
        for (int k = 1; k <= 5; k++) begin
            tick();
            n_vec++; if (tx_req !== (k == 5) || tx_data !== 8'hC3 || level !== 4'd1) begin
                n_err++; $display("FAIL retry_cyc%0d req=%b data=%h level=%0d", k, tx_req, tx_data, level); end
        end
        auto_resp = 1; resp_cnt = 3; tx_busy = 1;
        repeat (20) tick();
        n_vec++; if (level !== 4'd0 || tx_data !== 8'h3C) begin
            n_err++; $display("FAIL retry_drain level=%0d data=%h want 0/3c", level, tx_data); end
    endtask

    task automatic test_reset_mid();
        auto_resp = 0; tx_busy = 0;
        wr_data = 8'h77; wr_en = 1; tick(); wr_en = 0; tick();
        tx_busy = 1;
        for (int i = 0; i < 3; i++) begin wr_data = 8'h81 + 8'(i); wr_en = 1; tick(); end
        wr_en = 0;
        n_vec++; if (level !== 4'd3) begin n_err++; $display("FAIL rmid_queued got %0d want 3", level); end
        rst_n = 0; wr_en = 1; wr_data = 8'h99; clr_ovf = 1; tick(); wr_en = 0; clr_ovf = 0;
        n_vec++; if (level !== 4'd0 || empty !== 1'b1 || tx_req !== 1'b0 || tx_data !== 8'h00) begin
            n_err++; $display("FAIL rmid_reset level=%0d empty=%b req=%b data=%h want 0/1/0/00",
                              level, empty, tx_req, tx_data); end
        rst_n = 1; tx_busy = 0; pulses = 0;
        repeat (12) tick();
        n_vec++; if (pulses != 0) begin n_err++; $display("FAIL rmid_quiet pulses=%0d want 0", pulses); end
    endtask

    task automatic test_overflow_clear();
        tx_busy = 1;
        for (int i = 0; i < 9; i++) begin wr_data = 8'($urandom); wr_en = 1; tick(); end
        wr_en = 0;
        n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set got %b want 1", overflow); end
        clr_ovf = 1; tick(); clr_ovf = 0;
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clr got %b want 0", overflow); end
        clr_ovf = 1; wr_en = 1; tick(); clr_ovf = 0; wr_en = 0;
        n_vec++; if (overflow !== 1'b1 || level !== 4'd8) begin
            n_err++; $display("FAIL ovf_setwins ovf=%b level=%0d want 1/8", overflow, level); end
        rst_n = 0; tick(); rst_n = 1; tx_busy = 0;
    endtask

    task automatic test_random();
        int wr_pct;
        for (int c = 0; c < 1600; c++) begin
            auto_resp = (c >= 800);
            wr_pct  = ((c / 100) % 2 == 0) ? 70 : 20;
            wr_en   = ($urandom_range(0, 99) < wr_pct);
            wr_data = 8'($urandom);
            clr_ovf = ($urandom_range(0, 15) == 0);
            rst_n   = ($urandom_range(0, 299) != 0);
            if (!auto_resp) tx_busy = ($urandom_range(0, 2) == 0);
            tick();
            n_vec++; if (tx_req !== m_req || tx_data !== m_txd) begin
                n_err++; $display("FAIL rand_tx c=%0d req=%b data=%h want %b/%h", c, tx_req, tx_data, m_req, m_txd); end
            n_vec++; if (level !== 4'(mq.size()) || full !== (mq.size() == DEPTH) || empty !== (mq.size() == 0)) begin
                n_err++; $display("FAIL rand_level c=%0d level=%0d full=%b empty=%b want level %0d",
                                  c, level, full, empty, mq.size()); end
            n_vec++; if (overflow !== m_ovf) begin
                n_err++; $display("FAIL rand_ovf c=%0d got %b want %b", c, overflow, m_ovf); end
        end
        rst_n = 1; wr_en = 0; clr_ovf = 0; auto_resp = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_byte();
        test_fill_order();
        test_push_pop_full();
        test_retry();
        test_reset_mid();
        test_overflow_clear();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
